// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage.
//   state_t   : access FSM states (IDLE/REQ/WAIT/DONE)
//   F3_*      : funct3 encodings of the supported access sizes
//   ERR_*     : fault cause codes reported on err_cause_o
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_UNSUP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-bus bundle between the load/store unit and data memory.
//   mem_req_o    : bus request (held until grant)
//   mem_we_o     : 1 = write
//   mem_addr_o   : word-aligned byte address
//   mem_be_o     : byte enables
//   mem_wdata_o  : lane-steered store data
//   mem_gnt_i    : request accepted this cycle
//   mem_rvalid_i : read data valid
//   mem_rdata_i  : read data word
// master = load/store unit side, slave = memory side.
interface lsu_mem_stage_if;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the load/store unit.
// Request side (current instruction):
//   rd, wr      : load / store request
//   funct3      : access size/sign
//   addr_lo     : low two address bits
//   wdata       : raw store data (rs2)
//   be          : byte enables
//   wdata_lane  : store data replicated onto the addressed lanes (0 for loads)
//   misalign    : access not naturally aligned
//   unsup       : illegal operation/funct3 combination
// Response side (latched access):
//   ld_funct3, ld_addr_lo : latched size/sign and low address bits
//   rdata                 : raw memory word
//   rdata_ext             : selected and extended load value
module lsu_align
  import lsu_pkg::*;
(
  input  logic        rd,
  input  logic        wr,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misalign,
  output logic        unsup,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // funct3[1:0] encodes the access size for both signed and unsigned forms
  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      2'b10: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
      default: begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
      end
    endcase
    if (!wr) wdata_lane = 32'h0;
  end

  always_comb begin
    unsup = (rd & wr)
          | (rd & ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)))
          | (wr & ~((funct3 == F3_B) | (funct3 == F3_H) | (funct3 == F3_W)));
    misalign = ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00))
             | ((funct3[1:0] == 2'b01) & addr_lo[0]);
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_ext = {24'h0, byte_sel};
      F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_ext = {16'h0, half_sel};
      F3_W:    rdata_ext = rdata;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Multi-cycle load/store unit between execute and writeback.
// Accepts one access from execute, runs it over a req/gnt/rvalid data bus,
// and stalls the core until a one-cycle done_o pulse.
//   clk, rst        : clock, synchronous active-low reset
//   valid_i         : execute presents an instruction
//   memread_i/memwrite_i : load / store request
//   funct3_i, addr_i, wdata_i : access size/sign, byte address, store data
//   stall_o         : hold PC and decode/execute inputs
//   done_o          : access finished; rdata_o/err_o/err_cause_o valid
//   rdata_o         : extended load data (0 for stores/errors)
//   err_o, err_cause_o : fault flag and cause (01 misaligned, 10 unsupported, 11 timeout)
//   bus             : data-bus master port
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  lsu_mem_stage_if.master bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;
  logic [2:0]       req_f3;
  logic [1:0]       req_lo;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [1:0]       cause_q;

  logic             op;
  logic             timeout_hit;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic             misalign_c;
  logic             unsup_c;
  logic [31:0]      rdata_ext;
  logic [CNT_W-1:0] cnt_next;

  assign op          = valid_i & (memread_i | memwrite_i);
  assign timeout_hit = (cnt == CNT_LAST);
  // Saturate so a grant on the last allowed cycle leaves no extra budget in WAIT
  assign cnt_next    = timeout_hit ? cnt : cnt + 1'b1;

  lsu_align u_align (
    .rd         (memread_i),
    .wr         (memwrite_i),
    .funct3     (funct3_i),
    .addr_lo    (addr_i[1:0]),
    .wdata      (wdata_i),
    .be         (be_c),
    .wdata_lane (wdata_c),
    .misalign   (misalign_c),
    .unsup      (unsup_c),
    .ld_funct3  (req_f3),
    .ld_addr_lo (req_lo),
    .rdata      (bus.mem_rdata_i),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_we    <= 1'b0;
      req_addr  <= 32'h0;
      req_be    <= 4'h0;
      req_wdata <= 32'h0;
      req_f3    <= 3'h0;
      req_lo    <= 2'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (op) begin
            req_we    <= memwrite_i;
            req_addr  <= {addr_i[31:2], 2'b00};
            req_be    <= be_c;
            req_wdata <= wdata_c;
            req_f3    <= funct3_i;
            req_lo    <= addr_i[1:0];
            // Faulting accesses never touch the bus
            if (unsup_c | misalign_c) begin
              state   <= DONE;
              err_q   <= 1'b1;
              cause_q <= unsup_c ? ERR_UNSUP : ERR_MISALIGN;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt_next;
          if (bus.mem_gnt_i) begin
            state <= req_we ? DONE : WAIT;
          end else if (timeout_hit) begin
            state   <= DONE;
            err_q   <= 1'b1;
            cause_q <= ERR_TIMEOUT;
            rdata_q <= 32'h0;
          end
        end
        WAIT: begin
          cnt <= cnt_next;
          if (bus.mem_rvalid_i) begin
            state   <= DONE;
            rdata_q <= rdata_ext;
          end else if (timeout_hit) begin
            state   <= DONE;
            err_q   <= 1'b1;
            cause_q <= ERR_TIMEOUT;
            rdata_q <= 32'h0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          cause_q <= 2'b00;
        end
      endcase
    end
  end

  assign bus.mem_req_o   = (state == REQ);
  assign bus.mem_we_o    = req_we;
  assign bus.mem_addr_o  = req_addr;
  assign bus.mem_be_o    = req_be;
  assign bus.mem_wdata_o = req_wdata;

  assign stall_o     = (state == REQ) | (state == WAIT) | ((state == IDLE) & op);
  assign done_o      = (state == DONE);
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign err_cause_o = cause_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: stores, loads with extension, fault
// classification, timeout and reset during an access.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        rd;
  logic        wr;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wd;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  cause;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid),
    .memread_i   (rd),
    .memwrite_i  (wr),
    .funct3_i    (f3),
    .addr_i      (addr),
    .wdata_i     (wd),
    .stall_o     (stall),
    .done_o      (done),
    .rdata_o     (rdata),
    .err_o       (err),
    .err_cause_o (cause),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op in IDLE for one cycle; returns #1 after the accept edge
  task automatic start(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; rd = r; wr = w; f3 = f; addr = a; wd = d;
    #1;
    check("accept_stall", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    valid = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  // Zero-wait load: returns in DONE with the REQ-cycle byte enables
  task automatic load_txn(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] word, output logic [3:0] be_seen);
    start(1'b1, 1'b0, f, a, 32'h0);
    be_seen = bus.mem_be_o;
    bus.mem_gnt_i = 1'b1;
    step();
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = word;
    step();
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic check_err(input string tag, input logic [1:0] exp_cause);
    check({tag, "_req"},   {31'h0, bus.mem_req_o}, 32'h0);
    check({tag, "_done"},  {31'h0, done}, 32'h1);
    check({tag, "_err"},   {31'h0, err}, 32'h1);
    check({tag, "_cause"}, {30'h0, cause}, {30'h0, exp_cause});
    check({tag, "_rdata"}, rdata, 32'h0);
    step();
  endtask

  logic [3:0] be_s;

  initial begin
    rst = 1'b0; valid = 1'b0; rd = 1'b0; wr = 1'b0; f3 = 3'h0; addr = 32'h0; wd = 32'h0;
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_done",  {31'h0, done}, 32'h0);
    check("rst_req",   {31'h0, bus.mem_req_o}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err",   {30'h0, err, 1'b0} | {30'h0, cause}, 32'h0);
    rst = 1'b1;
    step();

    // sw 0x10
    start(1'b0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    check("sw_req",   {31'h0, bus.mem_req_o}, 32'h1);
    check("sw_we",    {31'h0, bus.mem_we_o}, 32'h1);
    check("sw_addr",  bus.mem_addr_o, 32'h10);
    check("sw_be",    {28'h0, bus.mem_be_o}, 32'hF);
    check("sw_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
    bus.mem_gnt_i = 1'b1;
    step();
    bus.mem_gnt_i = 1'b0;
    check("sw_done",  {31'h0, done}, 32'h1);
    check("sw_err",   {31'h0, err}, 32'h0);
    check("sw_stall", {31'h0, stall}, 32'h0);
    check("sw_rdata", rdata, 32'h0);
    step();
    check("sw_done_clr", {31'h0, done}, 32'h0);

    // lb / lbu 0x13 on 0x80FF1234
    load_txn(F3_B, 32'h13, 32'h80FF1234, be_s);
    check("lb_be",    {28'h0, be_s}, 32'h8);
    check("lb_done",  {31'h0, done}, 32'h1);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    step();
    check("lb_rdata_clr", rdata, 32'h0);
    load_txn(F3_BU, 32'h13, 32'h80FF1234, be_s);
    check("lbu_rdata", rdata, 32'h00000080);
    step();

    // sh 0x22, sb 0x21
    start(1'b0, 1'b1, F3_H, 32'h22, 32'h0000ABCD);
    check("sh_addr",  bus.mem_addr_o, 32'h20);
    check("sh_be",    {28'h0, bus.mem_be_o}, 32'hC);
    check("sh_wdata", bus.mem_wdata_o, 32'hABCDABCD);
    bus.mem_gnt_i = 1'b1;
    step();
    bus.mem_gnt_i = 1'b0;
    check("sh_done", {31'h0, done}, 32'h1);
    step();
    start(1'b0, 1'b1, F3_B, 32'h21, 32'h11223344);
    check("sb_be",    {28'h0, bus.mem_be_o}, 32'h2);
    check("sb_wdata", bus.mem_wdata_o, 32'h44444444);
    bus.mem_gnt_i = 1'b1;
    step();
    bus.mem_gnt_i = 1'b0;
    step();

    // halfword loads
    load_txn(F3_H, 32'h22, 32'h7FFF0000, be_s);
    check("lh_be",    {28'h0, be_s}, 32'hC);
    check("lh_rdata", rdata, 32'h00007FFF);
    step();
    load_txn(F3_H, 32'h00, 32'h1234ABCD, be_s);
    check("lh_neg_rdata", rdata, 32'hFFFFABCD);
    step();
    load_txn(F3_HU, 32'h02, 32'h8001ABCD, be_s);
    check("lhu_rdata", rdata, 32'h00008001);
    step();

    // lw with late grant and late rvalid; bus signals held stable
    start(1'b1, 1'b0, F3_W, 32'h44, 32'h0);
    for (int i = 0; i < 2; i++) begin
      check("lw_hold_req",  {31'h0, bus.mem_req_o}, 32'h1);
      check("lw_hold_addr", bus.mem_addr_o, 32'h44);
      check("lw_hold_wdat", bus.mem_wdata_o, 32'h0);
      step();
    end
    bus.mem_gnt_i = 1'b1;
    step();
    bus.mem_gnt_i = 1'b0;
    check("lw_wait_req",   {31'h0, bus.mem_req_o}, 32'h0);
    check("lw_wait_stall", {31'h0, stall}, 32'h1);
    step();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = 32'hCAFEF00D;
    step();
    bus.mem_rvalid_i = 1'b0;
    check("lw_done",  {31'h0, done}, 32'h1);
    check("lw_rdata", rdata, 32'hCAFEF00D);
    step();

    // faults
    start(1'b1, 1'b0, F3_W, 32'h06, 32'h0);
    check_err("lw_mis", ERR_MISALIGN);
    start(1'b1, 1'b0, F3_HU, 32'h01, 32'h0);
    check_err("lhu_mis", ERR_MISALIGN);
    start(1'b1, 1'b1, F3_W, 32'h10, 32'h0);
    check_err("rdwr_unsup", ERR_UNSUP);
    start(1'b1, 1'b0, 3'b011, 32'h01, 32'h0);
    check_err("ld011_unsup", ERR_UNSUP);
    start(1'b0, 1'b1, F3_BU, 32'h00, 32'h0);
    check_err("st100_unsup", ERR_UNSUP);

    // timeout: 8 request cycles then fault, later bus activity ignored
    start(1'b0, 1'b1, F3_W, 32'h40, 32'h5);
    for (int i = 0; i < 8; i++) begin
      check("to_req", {31'h0, bus.mem_req_o}, 32'h1);
      step();
    end
    check("to_done",  {31'h0, done}, 32'h1);
    check("to_err",   {31'h0, err}, 32'h1);
    check("to_cause", {30'h0, cause}, {30'h0, ERR_TIMEOUT});
    check("to_rdata", rdata, 32'h0);
    step();
    bus.mem_gnt_i = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("to_late_done", {31'h0, done}, 32'h0);
      check("to_late_stall", {31'h0, stall}, 32'h0);
      step();
    end
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;

    // reset while waiting for read data
    start(1'b1, 1'b0, F3_W, 32'h30, 32'h0);
    bus.mem_gnt_i = 1'b1;
    step();
    bus.mem_gnt_i = 1'b0;
    check("rw_in_wait", {31'h0, stall}, 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rw_stall", {31'h0, stall}, 32'h0);
    check("rw_done",  {31'h0, done}, 32'h0);
    check("rw_req",   {31'h0, bus.mem_req_o}, 32'h0);
    check("rw_addr",  bus.mem_addr_o, 32'h0);
    check("rw_be",    {28'h0, bus.mem_be_o}, 32'h0);
    check("rw_rdata", rdata, 32'h0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rw_late_done", {31'h0, done}, 32'h0);
    end
    bus.mem_rvalid_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Multi-cycle load/store unit that replaces the combinational data memory access between execute and writeback.
- Takes the effective address (ALU result), the store data (rs2) and funct3.
- Drives a request/grant/rvalid data bus with byte enables, sign/zero-extends load data, and stalls the core until the access completes.
- Supports lb/lh/lw/lbu/lhu/sb/sh/sw and flags misaligned, unsupported and timed-out accesses.

Parameters:
TIMEOUT_CYC, 64, total cycles allowed in REQ+WAIT before the access aborts (must be >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
valid_i  in  1  execute stage presents an instruction this cycle
memread_i  in  1  load request
memwrite_i  in  1  store request
funct3_i  in  3  access size/sign (inst[14:12])
addr_i  in  32  effective byte address
wdata_i  in  32  store data
stall_o  out  1  hold PC and decode/execute inputs
done_o  out  1  one-cycle pulse: access finished, rdata_o/err valid
rdata_o  out  32  extended load data (0 for stores/errors)
err_o  out  1  access faulted (valid with done_o)
err_cause_o  out  2  01 misaligned, 10 unsupported op, 11 timeout
mem_req_o  out  1  bus request
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word address {addr[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-steered store data
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data word

Behaviour:
- Reset (rst=0 at posedge): state IDLE, timeout counter 0, every registered output 0. Reset mid-access abandons the access; mem_req_o drops at that edge.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - An op is valid_i & (memread_i | memwrite_i).
  - On an op, latch addr/wdata/funct3/we and compute be/steered data and error.
  - With an error: go to DONE and issue no bus request.
  - Without an error: go to REQ.
  - stall_o is combinationally 1 in the accepting cycle.
- Error classification at accept:
  - Unsupported (10): memread_i & memwrite_i; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
  - Misaligned (01): word access with addr[1:0]!=0, or halfword access with addr[0]=1.
  - Unsupported takes priority over misaligned.
- REQ:
  - mem_req_o=1; mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are held stable until mem_gnt_i.
  - On gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: mem_req_o=0. mem_rvalid_i is sampled only here (it must arrive >=1 cycle after gnt). On rvalid, register the extended data and go to DONE.
- DONE:
  - done_o=1 and stall_o=0 for exactly one cycle; rdata_o, err_o and err_cause_o are valid; next state IDLE.
  - valid_i is ignored in DONE because the core advances this cycle.
  - rdata_o and the error outputs clear to 0 on DONE exit.
- stall_o=1 in REQ, WAIT and the IDLE accept cycle; 0 otherwise.
- Timeout:
  - The counter clears in IDLE and increments each cycle in REQ/WAIT.
  - If it reaches TIMEOUT_CYC-1 without the awaited gnt/rvalid, go to DONE with err 11 and rdata 0. A gnt/rvalid in that same cycle wins.
  - rvalid arriving in IDLE/DONE is ignored.
- Byte lanes, k = addr[1:0]:
  - sb: be = 1<<k, wdata = {4{wdata[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - sw: be = 1111, wdata unchanged.
  - Loads drive the same be and mem_wdata_o=0.
- Load extension: select byte k or half addr[1]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Latency (zero-wait bus): store 3 cycles (accept, REQ, DONE); load 4 cycles (accept, REQ, WAIT, DONE); error 2 cycles.

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE/REQ/WAIT/DONE)
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - cause codes ERR_MISALIGN=01, ERR_UNSUP=10, ERR_TIMEOUT=11
- Sub-module lsu_align (combinational): funct3+addr+wdata -> be, steered wdata, misaligned/unsupported flags; funct3+addr+rdata word -> extended load data.
- The FSM and timeout counter stay in lsu_mem_stage.

Test Plan:
1. sw addr=0x10, wdata=0xDEADBEEF, gnt in first REQ cycle -> mem_addr_o=0x10, be=1111, we=1, mem_wdata_o=0xDEADBEEF; done_o at cycle 2, err_o=0.
2. lb addr=0x13, mem_rdata_i=0x80FF1234 (rvalid 1 cycle after gnt) -> be=1000, rdata_o=0xFFFFFF80; repeat as lbu -> 0x00000080.
3. sh addr=0x22, wdata=0x0000ABCD -> mem_addr_o=0x20, be=1100, mem_wdata_o=0xABCDABCD; lh addr=0x22 on rdata 0x7FFF0000 -> rdata_o=0x00007FFF.
4. lw addr=0x06 -> mem_req_o never asserts, done_o next cycle, err_cause_o=01, rdata_o=0; memread_i=memwrite_i=1 -> cause 10.
5. TIMEOUT_CYC=8, gnt held low -> mem_req_o high 8 cycles, then done_o with err_cause_o=11; a later gnt/rvalid causes no second done_o.
6. rst=0 while in WAIT -> next cycle IDLE, stall_o=0, all outputs 0; rvalid pulsed afterwards produces no done_o.
